// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode-side IF/ID handoff and redirect input.
// FETCH_PERF_CNT_EN adds the perf_fetched/perf_bubbles counter outputs.
interface instr_fetch_unit_if;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_fault;
    logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    modport master (
        output imem_address,
        input  imem_instruction,
        input  id_ready,
        input  redirect_valid,
        input  redirect_target,
        output if_id_valid,
        output if_id_instr,
        output if_id_pc,
        output if_id_pc_plus4,
        output if_id_fault,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched,
        output perf_bubbles,
`endif
        output fetch_misalign
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output id_ready,
        output redirect_valid,
        output redirect_target,
        input  if_id_valid,
        input  if_id_instr,
        input  if_id_pc,
        input  if_id_pc_plus4,
        input  if_id_fault,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched,
        input  perf_bubbles,
`endif
        input  fetch_misalign
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner + IF/ID register; one-edge fetch latency, holds on decode stall, redirect beats stall.
// Optional FETCH_PERF_CNT_EN adds accepted-instruction and bubble counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          IMEM_ADDR_BITS = 8,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_fault;
    logic        r_misalign;

    logic        w_advance;
    logic        w_in_range;
    logic [31:0] w_pc_plus4;

    assign w_advance  = !r_valid || bus.id_ready;
    assign w_in_range = (r_pc[31:IMEM_ADDR_BITS] == '0);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_fault    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc       <= {bus.redirect_target[31:2], 2'b00};
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_fault    <= 1'b0;
            r_misalign <= |bus.redirect_target[1:0];
        end else begin
            r_misalign <= 1'b0;
            if (w_advance) begin
                r_pc     <= w_pc_plus4;
                r_valid  <= 1'b1;
                r_id_pc  <= r_pc;
                r_id_pc4 <= w_pc_plus4;
                // Out-of-range fetches never forward aliased memory contents.
                r_instr  <= w_in_range ? bus.imem_instruction : NOP_INSTR;
                r_fault  <= !w_in_range;
            end
        end
    end

    assign bus.imem_address   = r_pc;
    assign bus.if_id_valid    = r_valid;
    assign bus.if_id_instr    = r_instr;
    assign bus.if_id_pc       = r_id_pc;
    assign bus.if_id_pc_plus4 = r_id_pc4;
    assign bus.if_id_fault    = r_fault;
    assign bus.fetch_misalign = r_misalign;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_bubbles <= 32'd0;
        end else if (bus.id_ready) begin
            if (r_valid) r_perf_fetched <= r_perf_fetched + 32'd1;
            else         r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_bubbles = r_perf_bubbles;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level reference model.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned MEM_BYTES = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .IMEM_ADDR_BITS(8),
        .NOP_INSTR     (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory aliases above 0xFF so a leak of out-of-range data would be visible.
    logic [31:0] mem [64];
    assign bus.imem_instruction = mem[bus.imem_address[7:2]];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fetched, m_bubbles;
    logic        m_valid, m_fault, m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("imem_address", bus.imem_address, m_pc);
        check("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
        check("if_id_instr", bus.if_id_instr, m_instr);
        check("if_id_pc", bus.if_id_pc, m_ipc);
        check("if_id_pc_plus4", bus.if_id_pc_plus4, m_ipc4);
        check("if_id_fault", {31'd0, bus.if_id_fault}, {31'd0, m_fault});
        check("fetch_misalign", {31'd0, bus.fetch_misalign}, {31'd0, m_mis});
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", bus.perf_fetched, m_fetched);
        check("perf_bubbles", bus.perf_bubbles, m_bubbles);
`endif
    endtask

    // Applies the fetch rules to the model for one clock edge, then compares.
    task automatic step();
        logic [31:0] n_pc, n_instr, n_ipc, n_ipc4, n_fetched, n_bubbles;
        logic        n_valid, n_fault, n_mis;
        n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc; n_ipc4 = m_ipc4;
        n_valid = m_valid; n_fault = m_fault; n_mis = 1'b0;
        n_fetched = m_fetched; n_bubbles = m_bubbles;
        if (reset) begin
            n_pc = 32'd0; n_valid = 1'b0; n_instr = NOP; n_ipc = 32'd0;
            n_ipc4 = 32'd0; n_fault = 1'b0; n_fetched = 32'd0; n_bubbles = 32'd0;
        end else begin
            if (bus.id_ready && m_valid)  n_fetched = m_fetched + 1;
            if (bus.id_ready && !m_valid) n_bubbles = m_bubbles + 1;
            if (bus.redirect_valid) begin
                n_pc    = bus.redirect_target & ~32'd3;
                n_valid = 1'b0;
                n_instr = NOP;
                n_fault = 1'b0;
                n_mis   = (bus.redirect_target % 4) != 0;
            end else if (!m_valid || bus.id_ready) begin
                n_ipc   = m_pc;
                n_ipc4  = m_pc + 4;
                n_pc    = m_pc + 4;
                n_valid = 1'b1;
                if (m_pc < MEM_BYTES) begin
                    n_instr = mem[m_pc / 4];
                    n_fault = 1'b0;
                end else begin
                    n_instr = NOP;
                    n_fault = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc; m_ipc4 = n_ipc4;
        m_valid = n_valid; m_fault = n_fault; m_mis = n_mis;
        m_fetched = n_fetched; m_bubbles = n_bubbles;
        compare_all();
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
        reset = rst;
        bus.id_ready = rdy;
        bus.redirect_valid = rv;
        bus.redirect_target = tgt;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0000_10B7;
        mem[2] = 32'h0000_A183;
        mem[3] = 32'hE000_0113;
        m_fetched = 0; m_bubbles = 0;

        drive(1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        step();
        step();
        check("rst_instr", bus.if_id_instr, NOP);
        check("rst_pc", bus.imem_address, 32'd0);

        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        check("e1_pc", bus.if_id_pc, 32'h00);
        check("e1_instr", bus.if_id_instr, 32'h0000_0013);
        check("e1_addr", bus.imem_address, 32'h04);
        step();
        check("e2_instr", bus.if_id_instr, 32'h0000_10B7);
        step();
        check("e3_pc", bus.if_id_pc, 32'h08);
        check("e3_instr", bus.if_id_instr, 32'h0000_A183);

        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("stall_pc", bus.if_id_pc, 32'h08);
        check("stall_addr", bus.imem_address, 32'h0C);
        bus.id_ready = 1'b1;
        step();
        check("rel_pc", bus.if_id_pc, 32'h0C);
        check("rel_instr", bus.if_id_instr, 32'hE000_0113);
        step();
        bus.id_ready = 1'b0;
        step();
        check("hold10_pc", bus.if_id_pc, 32'h10);

        drive(1'b0, 1'b0, 1'b1, 32'h04);
        step();
        check("flush_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check("flush_instr", bus.if_id_instr, NOP);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        check("redir_pc", bus.if_id_pc, 32'h04);
        check("redir_instr", bus.if_id_instr, 32'h0000_10B7);

        drive(1'b0, 1'b1, 1'b1, 32'h0000_000A);
        step();
        check("mis_pulse", {31'd0, bus.fetch_misalign}, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        check("mis_clear", {31'd0, bus.fetch_misalign}, 32'd0);
        check("mis_pc", bus.if_id_pc, 32'h08);

        drive(1'b0, 1'b1, 1'b1, 32'h0000_00FC);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        check("fc_pc", bus.if_id_pc, 32'hFC);
        check("fc_fault", {31'd0, bus.if_id_fault}, 32'd0);
        step();
        check("oor_pc", bus.if_id_pc, 32'h100);
        check("oor_instr", bus.if_id_instr, NOP);
        check("oor_fault", {31'd0, bus.if_id_fault}, 32'd1);

        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("wrap_pc", bus.if_id_pc, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: tgt = $urandom_range(0, 32'h13F);
            endcase
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, tgt);
            step();
        end

        drive(1'b0, 1'b1, 1'b1, 32'h20);
        step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        bus.id_ready = 1'b0;
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0033);
        step();
        check("rst_mid_valid", {31'd0, bus.if_id_valid}, 32'd0);
        check("rst_mid_addr", bus.imem_address, 32'd0);
        check("rst_mid_mis", {31'd0, bus.fetch_misalign}, 32'd0);
        check("rst_mid_ipc", bus.if_id_pc, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
